// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master, MSB first, full duplex, one word per valid/ready.
// Registered pins; miso is sampled on the internal sclk-rise event.
//
// Ports:
//   clk, rst (async, active low)
//   tx_data/tx_valid/tx_ready : word in, accepted when idle
//   rx_data/rx_valid          : received word, 1-cycle strobe
//   busy                      : frame in progress
//   sclk/ss/mosi/miso         : SPI pins
module spi_master_ctrl #(
  parameter int DATA_W     = 16,
  parameter int CLK_DIV    = 4,
  parameter int SS_SETUP   = 2,
  parameter int SS_HOLD    = 2,
  parameter int GAP_CYC    = 4,
  parameter int SCLK_TRAIL = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              sclk,
  output logic              ss,
  output logic              mosi,
  input  logic              miso
);

  localparam int RISES = DATA_W + SCLK_TRAIL;
  localparam int RC_W  = $clog2(RISES + 1);

  localparam int M1 =
    (CLK_DIV > SS_SETUP) ? CLK_DIV : SS_SETUP;
  localparam int M2 =
    (SS_HOLD > GAP_CYC) ? SS_HOLD : GAP_CYC;
  localparam int CMAX  = (M1 > M2) ? M1 : M2;
  localparam int CNT_W = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [CNT_W-1:0] DIV_END =
    CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] SET_END =
    CNT_W'(SS_SETUP - 1);
  localparam logic [CNT_W-1:0] HLD_END =
    CNT_W'(SS_HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_END =
    CNT_W'(GAP_CYC - 1);
  localparam logic [RC_W-1:0]  RC_DATA =
    RC_W'(DATA_W);
  localparam logic [RC_W-1:0]  RC_LAST =
    RC_W'(RISES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_GAP
  } state_t;

  state_t           state;
  state_t           state_d;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_d;
  logic             accept;
  logic             tick;
  logic             done;
  logic             rise;
  logic             fall;

  logic [DATA_W-1:0] tx_shift;
  logic [DATA_W-1:0] rx_shift;
  logic [RC_W-1:0]   rise_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt + CNT_W'(1);
    accept  = 1'b0;
    tick    = 1'b0;
    done    = 1'b0;
    unique case (state)
      S_IDLE: begin
        cnt_d = '0;
        if (tx_valid && tx_ready) begin
          accept  = 1'b1;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt == SET_END) begin
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (cnt == DIV_END) begin
          cnt_d = '0;
          tick  = 1'b1;
          // last fall: sclk is high and all rises done
          if (sclk && rise_cnt == RC_LAST)
            state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (cnt == HLD_END) begin
          cnt_d   = '0;
          done    = 1'b1;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (cnt == GAP_END) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign rise = tick && !sclk;
  assign fall = tick && sclk;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_ready <= 1'b1;
      busy     <= 1'b0;
      ss       <= 1'b1;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      rise_cnt <= '0;
    end else begin
      tx_ready <= (state_d == S_IDLE);
      busy     <= (state_d != S_IDLE);
      rx_valid <= 1'b0;

      if (accept) begin
        tx_shift <= tx_data;
        mosi     <= tx_data[DATA_W-1];
        ss       <= 1'b0;
        rise_cnt <= '0;
      end

      if (rise) begin
        sclk     <= 1'b1;
        rise_cnt <= rise_cnt + RC_W'(1);
        // trailing rises carry no data
        if (rise_cnt < RC_DATA)
          rx_shift <= {rx_shift[DATA_W-2:0], miso};
      end

      if (fall) begin
        sclk     <= 1'b0;
        tx_shift <= tx_shift << 1;
        if (rise_cnt < RC_DATA)
          mosi <= tx_shift[DATA_W-2];
        else
          mosi <= 1'b0;
      end

      if (done) begin
        ss       <= 1'b1;
        rx_data  <= rx_shift;
        rx_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl: default instance plus a
// CLK_DIV=1 instance, both with miso looped or tied.
module tb_spi_master_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        busy;
  logic        sclk;
  logic        ss;
  logic        mosi;
  logic        miso;
  logic        loop_en;
  logic        miso_k;

  logic [15:0] tx_data1;
  logic        tx_valid1;
  logic        tx_ready1;
  logic [15:0] rx_data1;
  logic        rx_valid1;
  logic        busy1;
  logic        sclk1;
  logic        ss1;
  logic        mosi1;
  logic        miso1;

  always #5 clk = ~clk;

  assign miso  = loop_en ? mosi : miso_k;
  assign miso1 = mosi1;

  spi_master_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .busy     (busy),
    .sclk     (sclk),
    .ss       (ss),
    .mosi     (mosi),
    .miso     (miso)
  );

  spi_master_ctrl #(.CLK_DIV(1)) dut1 (
    .clk      (clk),
    .rst      (rst),
    .tx_data  (tx_data1),
    .tx_valid (tx_valid1),
    .tx_ready (tx_ready1),
    .rx_data  (rx_data1),
    .rx_valid (rx_valid1),
    .busy     (busy1),
    .sclk     (sclk1),
    .ss       (ss1),
    .mosi     (mosi1),
    .miso     (miso1)
  );

  int checks = 0;
  int errors = 0;

  int ss_low_cnt = 0;
  int rise_m     = 0;
  int txr_cnt    = 0;
  int ss_hi_run  = 0;
  int last_gap   = 0;
  int cyc        = 0;
  int t_ssfall   = 0;
  int t_rise1    = 0;
  int rx_n       = 0;
  int slv_cnt    = 0;
  int slv_dv     = 0;
  logic [15:0] mosi_cap = '0;
  logic [15:0] slv_sh   = '0;
  logic [15:0] slv_data = '0;
  logic        mosi_or  = 1'b0;
  logic        sclk_q   = 1'b0;
  logic        ss_q     = 1'b1;
  logic [15:0] rx_log [4];

  // pin monitor and simple slave receiver model
  always @(negedge clk) begin
    cyc++;
    if (!ss) begin
      ss_low_cnt++;
      mosi_or = mosi_or | mosi;
      if (ss_q) begin
        last_gap = ss_hi_run;
        t_ssfall = cyc;
        slv_cnt  = 0;
      end
      ss_hi_run = 0;
    end else begin
      ss_hi_run++;
    end
    if (sclk && !sclk_q) begin
      rise_m++;
      if (rise_m == 1) t_rise1 = cyc;
      if (rise_m <= 16) mosi_cap = {mosi_cap[14:0], mosi};
      if (!ss) begin
        slv_cnt++;
        if (slv_cnt <= 16) slv_sh = {slv_sh[14:0], mosi};
        if (slv_cnt == 17) begin
          slv_data = slv_sh;
          slv_dv++;
        end
      end
    end
    if (rx_valid) begin
      if (rx_n < 4) rx_log[rx_n] = rx_data;
      rx_n++;
    end
    if (tx_ready) txr_cnt++;
    sclk_q = sclk;
    ss_q   = ss;
  end

  task automatic clr();
    ss_low_cnt = 0;
    rise_m     = 0;
    rx_n       = 0;
    txr_cnt    = 0;
    mosi_cap   = '0;
    mosi_or    = 1'b0;
    slv_dv     = 0;
  endtask

  task automatic send(input logic [15:0] d);
    int n;
    n = 0;
    @(posedge clk); #1;
    tx_data  = d;
    tx_valid = 1'b1;
    while (!tx_ready && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (!tx_ready) begin
      errors++;
      $display("FAIL send_ready got %b want 1", tx_ready);
    end
    @(posedge clk); #1;
    tx_valid = 1'b0;
  endtask

  task automatic wait_rx(input int k);
    int n;
    n = 0;
    while (rx_n < k && n < 3000) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (rx_n < k) begin
      errors++;
      $display("FAIL rx_timeout got %0d want %0d", rx_n, k);
    end
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst       = 1'b0;
    tx_valid  = 1'b0;
    tx_data   = '0;
    tx_valid1 = 1'b0;
    tx_data1  = '0;
    loop_en   = 1'b1;
    miso_k    = 1'b0;
    #23;
    checks++;
    if ({ss, sclk, mosi} !== 3'b100) begin
      errors++;
      $display("FAIL rst_pins got %b want 100",
               {ss, sclk, mosi});
    end
    checks++;
    if ({rx_valid, busy} !== 2'b00) begin
      errors++;
      $display("FAIL rst_flags got %b want 00",
               {rx_valid, busy});
    end
    checks++;
    if (rx_data !== 16'h0000) begin
      errors++;
      $display("FAIL rst_rx_data got %h want 0000", rx_data);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({tx_ready, busy} !== 2'b10) begin
      errors++;
      $display("FAIL rst_ready got %b want 10",
               {tx_ready, busy});
    end
  endtask

  task automatic test_loopback();
    loop_en = 1'b1;
    clr();
    send(16'hA5C3);
    wait_rx(1);
    checks++;
    if (mosi_cap !== 16'hA5C3) begin
      errors++;
      $display("FAIL lb_mosi got %h want a5c3", mosi_cap);
    end
    checks++;
    if (rx_data !== 16'hA5C3 || rx_log[0] !== 16'hA5C3) begin
      errors++;
      $display("FAIL lb_rx got %h want a5c3", rx_data);
    end
    checks++;
    if (rise_m != 17) begin
      errors++;
      $display("FAIL lb_rises got %0d want 17", rise_m);
    end
    checks++;
    if (rx_n != 1) begin
      errors++;
      $display("FAIL lb_rxv_pulses got %0d want 1", rx_n);
    end
    checks++;
    if (ss_low_cnt != 140) begin
      errors++;
      $display("FAIL lb_ss_low got %0d want 140", ss_low_cnt);
    end
    checks++;
    if (t_rise1 - t_ssfall != 6) begin
      errors++;
      $display("FAIL lb_first_rise got %0d want 6",
               t_rise1 - t_ssfall);
    end
  endtask

  task automatic test_zero_miso_high();
    loop_en = 1'b0;
    miso_k  = 1'b1;
    clr();
    send(16'h0000);
    wait_rx(1);
    checks++;
    if (rx_data !== 16'hFFFF) begin
      errors++;
      $display("FAIL z_rx got %h want ffff", rx_data);
    end
    checks++;
    if (mosi_or !== 1'b0) begin
      errors++;
      $display("FAIL z_mosi got %b want 0", mosi_or);
    end
    checks++;
    if (ss_low_cnt != 140) begin
      errors++;
      $display("FAIL z_ss_low got %0d want 140", ss_low_cnt);
    end
    loop_en = 1'b1;
  endtask

  task automatic test_slave();
    loop_en = 1'b1;
    clr();
    send(16'hBEEF);
    wait_rx(1);
    checks++;
    if (slv_data !== 16'hBEEF || slv_dv != 1) begin
      errors++;
      $display("FAIL slave got %h/%0d want beef/1",
               slv_data, slv_dv);
    end
    checks++;
    if (rx_data !== 16'hBEEF) begin
      errors++;
      $display("FAIL slave_rx got %h want beef", rx_data);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    int txr_snap;
    int gap_snap;
    loop_en = 1'b1;
    clr();
    n = 0;
    @(posedge clk); #1;
    tx_data  = 16'h1234;
    tx_valid = 1'b1;
    while (tx_ready && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    tx_data = 16'h5678;
    txr_cnt = 0;
    while (!tx_ready && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    while (tx_ready && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    tx_valid = 1'b0;
    txr_snap = txr_cnt;
    gap_snap = last_gap;
    checks++;
    if (n >= 1000) begin
      errors++;
      $display("FAIL b2b_timeout got %0d want <1000", n);
    end
    wait_rx(2);
    checks++;
    if (rx_log[0] !== 16'h1234 || rx_log[1] !== 16'h5678) begin
      errors++;
      $display("FAIL b2b_rx got %h %h want 1234 5678",
               rx_log[0], rx_log[1]);
    end
    checks++;
    if (txr_snap != 1) begin
      errors++;
      $display("FAIL b2b_ready got %0d want 1", txr_snap);
    end
    checks++;
    if (gap_snap < 4) begin
      errors++;
      $display("FAIL b2b_gap got %0d want >=4", gap_snap);
    end
  endtask

  task automatic test_ignore_busy();
    loop_en = 1'b1;
    clr();
    send(16'h1357);
    repeat (20) @(posedge clk);
    #1;
    tx_data  = 16'h9999;
    tx_valid = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    tx_valid = 1'b0;
    tx_data  = '0;
    wait_rx(1);
    checks++;
    if (rx_data !== 16'h1357 || mosi_cap !== 16'h1357) begin
      errors++;
      $display("FAIL ign_frame got %h/%h want 1357",
               rx_data, mosi_cap);
    end
    checks++;
    if (rx_n != 1) begin
      errors++;
      $display("FAIL ign_rxv got %0d want 1", rx_n);
    end
    clr();
    send(16'h2468);
    wait_rx(1);
    checks++;
    if (rx_data !== 16'h2468 || mosi_cap !== 16'h2468) begin
      errors++;
      $display("FAIL ign_next got %h/%h want 2468",
               rx_data, mosi_cap);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    loop_en = 1'b1;
    clr();
    send(16'hF0F0);
    n = 0;
    while (rise_m < 7 && n < 500) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (rise_m < 7) begin
      errors++;
      $display("FAIL mid_rise7 got %0d want 7", rise_m);
    end
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if ({ss, sclk, busy, rx_valid} !== 4'b1000) begin
      errors++;
      $display("FAIL mid_pins got %b want 1000",
               {ss, sclk, busy, rx_valid});
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (rx_data !== 16'h0000) begin
      errors++;
      $display("FAIL mid_rx_data got %h want 0000", rx_data);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (rx_n != 0) begin
      errors++;
      $display("FAIL mid_rxv got %0d want 0", rx_n);
    end
    clr();
    send(16'h00FF);
    wait_rx(1);
    checks++;
    if (rx_data !== 16'h00FF) begin
      errors++;
      $display("FAIL mid_after got %h want 00ff", rx_data);
    end
  endtask

  task automatic test_div1();
    int low;
    int got;
    @(posedge clk); #1;
    tx_data1  = 16'hBEEF;
    tx_valid1 = 1'b1;
    checks++;
    if (tx_ready1 !== 1'b1) begin
      errors++;
      $display("FAIL d1_ready got %b want 1", tx_ready1);
    end
    @(posedge clk); #1;
    tx_valid1 = 1'b0;
    low = 0;
    got = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!ss1) low++;
      if (rx_valid1) got++;
    end
    checks++;
    if (rx_data1 !== 16'hBEEF || got != 1) begin
      errors++;
      $display("FAIL d1_rx got %h/%0d want beef/1",
               rx_data1, got);
    end
    checks++;
    if (low != 38) begin
      errors++;
      $display("FAIL d1_ss_low got %0d want 38", low);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_loopback();
    test_zero_miso_high();
    test_slave();
    test_back_to_back();
    test_ignore_busy();
    test_reset_mid();
    test_div1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
